// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin, burst-capped pop arbiter for two async-FIFO read ports feeding one valid/ready stream
module fifo_rd_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  en,
  input  logic                  r_empty0,
  input  logic [DATA_WIDTH-1:0] r_data0,
  output logic                  r_inc0,
  input  logic                  r_empty1,
  input  logic [DATA_WIDTH-1:0] r_data1,
  output logic                  r_inc1,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int BW = $clog2(BURST_MAX) + 1;
  localparam logic [BW-1:0] CAP = BW'(BURST_MAX);
  logic cool0, cool1, rr_last, elig0, elig1, slot_free, grant, pick;
  logic [BW-1:0] burst_cnt;
  always_comb begin
    slot_free = !out_valid || out_ready;
    elig0 = en && !r_empty0 && !cool0 && !R_RST;
    elig1 = en && !r_empty1 && !cool1 && !R_RST;
    // a fresh (count 0) or capped burst hands a tie to the other channel; otherwise stay
    pick = (elig0 && elig1) ? ((burst_cnt == '0 || burst_cnt == CAP) ? !rr_last : rr_last) : elig1;
    grant = slot_free && (elig0 || elig1);
    r_inc0 = grant && !pick;
    r_inc1 = grant && pick;
  end
  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= 1'b0;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
      cool0     <= 1'b0;
      cool1     <= 1'b0;
    end else begin
      cool0 <= r_inc0;
      cool1 <= r_inc1;
      if (grant) begin
        out_data  <= pick ? r_data1 : r_data0;
        out_ch    <= pick;
        out_valid <= 1'b1;
        rr_last   <= pick;
        burst_cnt <= (pick == rr_last && elig0 && elig1) ? ((burst_cnt == CAP) ? CAP : burst_cnt + 1'b1) : BW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: directed stimulus with a scoreboard queue checked by an independent output monitor
module tb_fifo_rd_arbiter;
  localparam int DW = 8;
  localparam int BM = 2;
  logic R_CLK = 1'b0, R_RST = 1'b1, en = 1'b1, out_ready = 1'b1;
  logic r_empty0 = 1'b1, r_empty1 = 1'b1;
  logic [DW-1:0] r_data0 = '0, r_data1 = '0, out_data;
  logic r_inc0, r_inc1, out_ch, out_valid;
  logic inc0_s = 1'b0, inc1_s = 1'b0, prev0 = 1'b0, prev1 = 1'b0;
  logic [DW-1:0] q0[$], q1[$];
  logic [DW:0] exp_q[$];
  int total = 0, passed = 0;

  always #5 R_CLK = ~R_CLK;

  fifo_rd_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .R_CLK(R_CLK), .R_RST(R_RST), .en(en),
    .r_empty0(r_empty0), .r_data0(r_data0), .r_inc0(r_inc0),
    .r_empty1(r_empty1), .r_data1(r_data1), .r_inc1(r_inc1),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endfunction

  // FIFO read-port model: empty flag reflects the occupancy before this edge's pop (one-cycle lag)
  always @(posedge R_CLK) begin
    r_empty0 <= (q0.size() == 0);
    r_empty1 <= (q1.size() == 0);
    if (inc0_s && q0.size() > 0) void'(q0.pop_front());
    if (inc1_s && q1.size() > 0) void'(q1.pop_front());
    r_data0 <= (q0.size() > 0) ? q0[0] : '0;
    r_data1 <= (q1.size() > 0) ? q1[0] : '0;
  end

  always @(negedge R_CLK) begin
    inc0_s = r_inc0;
    inc1_s = r_inc1;
    if (r_inc0 || r_inc1) begin
      chk("one_strobe", 32'(r_inc0 && r_inc1), 0);
      chk("pop_slot_free", 32'(out_valid && !out_ready), 0);
      chk("no_back_to_back", 32'((r_inc0 && prev0) || (r_inc1 && prev1)), 0);
      chk("pop_nonempty", 32'(r_inc0 ? q0.size() != 0 : q1.size() != 0), 1);
    end
    prev0 = r_inc0;
    prev1 = r_inc1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_word: got ch%0d %0h expected none", out_ch, out_data);
      end else chk("word", 32'({out_ch, out_data}), 32'(exp_q.pop_front()));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge R_CLK);
    #1;
  endtask

  task automatic load(logic ch, logic [DW-1:0] d);
    if (ch) q1.push_back(d);
    else q0.push_back(d);
  endtask

  task automatic expect_word(logic ch, logic [DW-1:0] d);
    exp_q.push_back({ch, d});
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      cyc(1);
      n++;
    end
    chk(name, 32'(out_valid), 1);
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cyc(1);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] t3_0[4] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    logic [DW-1:0] t3_1[4] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    // reset held while ch0 is non-empty and enabled
    load(0, 8'h5A);
    expect_word(0, 8'h5A);
    repeat (2) begin
      @(negedge R_CLK);
      chk("rst_inc0", 32'(r_inc0), 0);
      chk("rst_inc1", 32'(r_inc1), 0);
    end
    @(posedge R_CLK);
    #1 R_RST = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ch", 32'(out_ch), 0);
    wait_drain("t1_drain");
    // single-channel drain, one pop every other cycle
    cyc(3);
    foreach (t3_0[i]) if (i < 3) begin
      load(0, 8'hA1 + DW'(i));
      expect_word(0, 8'hA1 + DW'(i));
    end
    wait_drain("t2_drain");
    // interleave: ch0 wins the tie, then cooldown forces alternation
    cyc(3);
    foreach (t3_0[i]) begin
      load(0, t3_0[i]);
      load(1, t3_1[i]);
      expect_word(0, t3_0[i]);
      expect_word(1, t3_1[i]);
    end
    wait_valid("t3_first_valid");
    repeat (7) begin
      cyc(1);
      chk("t3_no_bubble", 32'(out_valid), 1);
    end
    wait_drain("t3_drain");
    // backpressure: ch1 stays (count 1), then the capped burst hands over to ch0
    cyc(3);
    out_ready = 1'b0;
    load(0, 8'hD0); load(0, 8'hD1);
    load(1, 8'hE0); load(1, 8'hE1);
    expect_word(1, 8'hE0); expect_word(0, 8'hD0);
    expect_word(1, 8'hE1); expect_word(0, 8'hD1);
    wait_valid("t4_valid");
    repeat (5) begin
      @(negedge R_CLK);
      chk("t4_hold_no_inc", 32'(r_inc0 | r_inc1), 0);
      chk("t4_hold_data", 32'(out_data), 32'hE0);
      chk("t4_hold_ch", 32'(out_ch), 1);
    end
    @(posedge R_CLK);
    #1 out_ready = 1'b1;
    @(negedge R_CLK);
    chk("t4_accept_and_pop", 32'(r_inc0), 1);
    wait_drain("t4_drain");
    // burst cap under single-cycle ready pulses with both channels eligible
    cyc(3);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) load(0, 8'hF0 + DW'(i));
    load(1, 8'h60); load(1, 8'h61);
    expect_word(0, 8'hF0); expect_word(1, 8'h60); expect_word(1, 8'h61);
    expect_word(0, 8'hF1); expect_word(0, 8'hF2); expect_word(0, 8'hF3);
    wait_valid("t5_valid");
    cyc(2);
    repeat (6) begin
      out_ready = 1'b1;
      cyc(1);
      out_ready = 1'b0;
      cyc(1);
    end
    wait_drain("t5_drain");
    out_ready = 1'b1;
    // en low: held word still drains, no new pops
    cyc(3);
    out_ready = 1'b0;
    load(0, 8'h70);
    expect_word(0, 8'h70);
    expect_word(0, 8'h71);
    wait_valid("t6_valid");
    en = 1'b0;
    load(0, 8'h71);
    cyc(2);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge R_CLK);
      chk("t6_no_pop", 32'(r_inc0 | r_inc1), 0);
    end
    @(posedge R_CLK);
    #1 chk("t6_drained", 32'(out_valid), 0);
    chk("t6_pending", exp_q.size(), 1);
    en = 1'b1;
    wait_drain("t6_drain");
    cyc(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
